// File: rtl/snoop_host.sv
// Host-side snoop bus master: decodes a byte command stream into program/data RAM
// writes, data RAM reads returned on a byte response stream, and CPU reset control.
module snoop_host #(
    parameter logic       CPU_RESET_INIT = 1'b1,
    parameter logic [7:0] ERR_BYTE       = 8'hEE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] snoopa,
    output logic [7:0] snoopd,
    output logic       snoopm,
    output logic       snoopp,
    input  logic [7:0] snoopq,
    output logic       cpu_reset,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_COUNT, GET_DATA, WRITE, RD_ADDR, RD_WAIT, RD_CAP, RSP
    } state_t;

    localparam logic [7:0] OP_WRD  = 8'h01;
    localparam logic [7:0] OP_WRP  = 8'h02;
    localparam logic [7:0] OP_RD   = 8'h03;
    localparam logic [7:0] OP_BWR  = 8'h04;
    localparam logic [7:0] OP_BRD  = 8'h05;
    localparam logic [7:0] OP_RST1 = 8'h06;
    localparam logic [7:0] OP_RST0 = 8'h07;

    state_t     state_q, state_d;
    logic [7:0] op_q, op_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] rsp_q, rsp_d;
    logic [8:0] cnt_q, cnt_d;
    logic       cpu_reset_q, cpu_reset_d;
    logic       cmd_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_q       <= '0;
            cnt_q       <= '0;
            cpu_reset_q <= CPU_RESET_INIT;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rsp_q       <= rsp_d;
            cnt_q       <= cnt_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    // Held low while reset is asserted so no byte is taken before the FSM runs.
    assign cmd_ready = !reset && (state_q == IDLE || state_q == GET_ADDR ||
                                  state_q == GET_COUNT || state_q == GET_DATA);
    assign cmd_fire  = cmd_valid && cmd_ready;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rsp_d       = rsp_q;
        cnt_d       = cnt_q;
        cpu_reset_d = cpu_reset_q;
        case (state_q)
            IDLE: if (cmd_fire) begin
                op_d = cmd_data;
                case (cmd_data)
                    OP_WRD, OP_WRP, OP_RD, OP_BWR, OP_BRD: state_d = GET_ADDR;
                    OP_RST1: cpu_reset_d = 1'b1;
                    OP_RST0: cpu_reset_d = 1'b0;
                    default: begin
                        rsp_d   = ERR_BYTE;
                        cnt_d   = 9'd1;
                        state_d = RSP;
                    end
                endcase
            end
            GET_ADDR: if (cmd_fire) begin
                addr_d = cmd_data;
                cnt_d  = 9'd1;
                if (op_q == OP_BWR || op_q == OP_BRD) state_d = GET_COUNT;
                else if (op_q == OP_RD)               state_d = RD_ADDR;
                else                                  state_d = GET_DATA;
            end
            GET_COUNT: if (cmd_fire) begin
                cnt_d   = {cmd_data == 8'h00, cmd_data};  // n=0 encodes 256
                state_d = (op_q == OP_BRD) ? RD_ADDR : GET_DATA;
            end
            GET_DATA: if (cmd_fire) begin
                data_d  = cmd_data;
                state_d = WRITE;
            end
            WRITE: begin
                if (cnt_q != 9'd1) begin
                    cnt_d   = cnt_q - 9'd1;
                    addr_d  = addr_q + 8'd1;
                    state_d = GET_DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: state_d = RD_CAP;
            RD_CAP: begin
                rsp_d   = snoopq;
                state_d = RSP;
            end
            RSP: if (rsp_ready) begin
                if (cnt_q != 9'd1) begin
                    cnt_d   = cnt_q - 9'd1;
                    addr_d  = addr_q + 8'd1;
                    state_d = RD_ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign snoopa    = addr_q;
    assign snoopd    = data_q;
    assign snoopm    = (state_q == WRITE) && (op_q == OP_WRD);
    assign snoopp    = (state_q == WRITE) && (op_q == OP_WRP || op_q == OP_BWR);
    assign rsp_data  = rsp_q;
    assign rsp_valid = (state_q == RSP);
    assign cpu_reset = cpu_reset_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_snoop_host.sv
// Scoreboard bench for snoop_host: expected strobes and response bytes are queued
// as commands are driven and checked by a monitor as the DUT produces them.
module tb_snoop_host;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] snoopa;
    logic [7:0] snoopd;
    logic       snoopm;
    logic       snoopp;
    logic [7:0] snoopq;
    logic       cpu_reset;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       prog;
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] rq[$];
    wr_t        mon_e;
    logic [7:0] mon_r;
    logic [7:0] dmem[256];
    logic [7:0] pmem[256];

    snoop_host #(.CPU_RESET_INIT(1'b1), .ERR_BYTE(8'hEE)) dut (
        .clk(clk), .reset(reset),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .snoopa(snoopa), .snoopd(snoopd), .snoopm(snoopm), .snoopp(snoopp),
        .snoopq(snoopq), .cpu_reset(cpu_reset), .busy(busy)
    );

    always #5 clk = ~clk;

    // Target-side RAMs with registered read data
    always @(posedge clk) begin
        if (snoopm) dmem[snoopa] <= snoopd;
        if (snoopp) pmem[snoopa] <= snoopd;
        snoopq <= dmem[snoopa];
    end

    // Monitor: every strobe and every response transfer is matched to the scoreboard
    always @(negedge clk) begin
        if (snoopm || snoopp) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected got p=%0b m=%0b a=%02h d=%02h expected no strobe",
                         snoopp, snoopm, snoopa, snoopd);
            end else begin
                mon_e = wq.pop_front();
                if ({snoopp, snoopm, snoopa, snoopd} !== {mon_e.prog, ~mon_e.prog, mon_e.a, mon_e.d}) begin
                    errors++;
                    $display("FAIL wr_strobe got p=%0b m=%0b a=%02h d=%02h expected p=%0b m=%0b a=%02h d=%02h",
                             snoopp, snoopm, snoopa, snoopd, mon_e.prog, ~mon_e.prog, mon_e.a, mon_e.d);
                end
            end
        end
        if (rsp_valid && rsp_ready) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got %02h expected no response", rsp_data);
            end else begin
                mon_r = rq.pop_front();
                if (rsp_data !== mon_r) begin
                    errors++;
                    $display("FAIL rsp_data got %02h expected %02h", rsp_data, mon_r);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL cmd_timeout got cmd_ready=0 expected 1 for byte %02h", b);
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got busy=%0b expected 0", busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr_data(input logic [7:0] a, input logic [7:0] d);
        wq.push_back('{prog: 1'b0, a: a, d: d});
        send_byte(8'h01);
        send_byte(a);
        send_byte(d);
        wait_idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_data = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_data, busy, snoopa, snoopd, snoopm, snoopp, cpu_reset} !==
            {1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values got rdy=%0b rv=%0b rd=%02h busy=%0b a=%02h d=%02h m=%0b p=%0b cr=%0b expected all 0 with cpu_reset=1",
                     cmd_ready, rsp_valid, rsp_data, busy, snoopa, snoopd, snoopm, snoopp, cpu_reset);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got cmd_ready=%0b cpu_reset=%0b expected 1 1", cmd_ready, cpu_reset);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_prog_write();
        wq.push_back('{prog: 1'b1, a: 8'h10, d: 8'hA7});
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'hA7);
        wait_idle();
    endtask

    task automatic test_read_latency();
        wr_data(8'h3C, 8'h5E);
        rsp_ready = 1'b0;
        send_byte(8'h03);
        send_byte(8'h3C);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rd_early got rsp_valid=%0b expected 0 at cycle %0d", rsp_valid, k);
            end
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h5E) begin
            errors++;
            $display("FAIL rd_latency got valid=%0b data=%02h expected 1 5e", rsp_valid, rsp_data);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h5E) begin
                errors++;
                $display("FAIL rd_hold got valid=%0b data=%02h expected 1 5e", rsp_valid, rsp_data);
            end
        end
        rq.push_back(8'h5E);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_burst_wrap();
        wq.push_back('{prog: 1'b1, a: 8'hFE, d: 8'h11});
        wq.push_back('{prog: 1'b1, a: 8'hFF, d: 8'h22});
        wq.push_back('{prog: 1'b1, a: 8'h00, d: 8'h33});
        send_byte(8'h04);
        send_byte(8'hFE);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        wait_idle();
        wr_data(8'hFE, 8'h81);
        wr_data(8'hFF, 8'h82);
        wr_data(8'h00, 8'h83);
        rq.push_back(8'h81);
        rq.push_back(8'h82);
        rq.push_back(8'h83);
        send_byte(8'h05);
        send_byte(8'hFE);
        send_byte(8'h03);
        wait_idle();
    endtask

    task automatic test_burst_256();
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            wq.push_back('{prog: 1'b1, a: a, d: a ^ 8'h5A});
        end
        send_byte(8'h04);
        send_byte(8'h00);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            send_byte(a ^ 8'h5A);
        end
        wait_idle();
        checks++;
        if (wq.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL burst256 got pending=%0d busy=%0b expected 0 0", wq.size(), busy);
        end
    endtask

    task automatic test_cpu_reset();
        send_byte(8'h07);
        checks++;
        if (cpu_reset !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cpu_reset_clr got cr=%0b busy=%0b expected 0 0", cpu_reset, busy);
        end
        send_byte(8'h06);
        checks++;
        if (cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL cpu_reset_set got %0b expected 1", cpu_reset);
        end
        send_byte(8'h07);
        checks++;
        if (cpu_reset !== 1'b0) begin
            errors++;
            $display("FAIL cpu_reset_clr2 got %0b expected 0", cpu_reset);
        end
    endtask

    task automatic test_bad_opcode();
        rq.push_back(8'hEE);
        send_byte(8'h09);
        wait_idle();
        checks++;
        if (rq.size() != 0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL bad_opcode got pending=%0d busy=%0b rdy=%0b expected 0 0 1", rq.size(), busy, cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        wq.push_back('{prog: 1'b1, a: 8'h20, d: 8'hAA});
        send_byte(8'h04);
        send_byte(8'h20);
        send_byte(8'h05);
        send_byte(8'hAA);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_getdata got busy=%0b rdy=%0b expected 1 1", busy, cmd_ready);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got busy=%0b rdy=%0b expected 0 0", busy, cmd_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || cpu_reset !== 1'b1 || wq.size() != 0) begin
            errors++;
            $display("FAIL mid_after got busy=%0b rdy=%0b cr=%0b pending=%0d expected 0 1 1 0",
                     busy, cmd_ready, cpu_reset, wq.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_prog_write();
        test_read_latency();
        test_burst_wrap();
        test_burst_256();
        test_cpu_reset();
        test_bad_opcode();
        test_reset_mid();
        checks++;
        if (wq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got wr=%0d rsp=%0d expected 0 0", wq.size(), rq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
